// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter
//   Round-robin arbiter between the write client (camera frame writer) and
//   the read client (HDR fetch engine). It is the only driver of the DDR
//   command FSM's cmd/cmd_valid inputs. It keeps one command outstanding at a
//   time, gates every issue on fsm_busy, and tracks the command until the FSM
//   returns to idle.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   init_done             memory initialisation complete (gates issuing)
//   wr_req/wr_addr        write client request and address
//   wr_grant/wr_done      write request latched / write command completed
//   rd_req/rd_addr        read client request and address
//   rd_grant/rd_done      read request latched / read command completed
//   cmd/cmd_valid         command code and strobe to the command FSM
//   cmd_addr              latched address of the in-flight command
//   fsm_busy              busy output of the command FSM
//   retry_cnt             saturating count of acknowledge-timeout re-issues
module ddr_cmd_arbiter #(
  parameter int ADDR_W      = 23,
  parameter bit AUTO_PRE    = 1'b1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_grant,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_done,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              fsm_busy,
  output logic [7:0]        retry_cnt
);

  localparam logic [3:0] CMD_RD = AUTO_PRE ? 4'b0011 : 4'b0001;
  localparam logic [3:0] CMD_WR = AUTO_PRE ? 4'b0100 : 4'b0010;

  // The timeout counter is loaded with ACK_TIMEOUT-1 in the strobe cycle, so
  // the block spends ACK_TIMEOUT cycles in WAIT_ACK before giving up.
  localparam int              TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              prio_wr_r, prio_wr_s;   // 1: write client wins a tie
  logic              is_wr_r, is_wr_s;       // type of the in-flight command
  logic [3:0]        cmd_r, cmd_s;
  logic [ADDR_W-1:0] cmd_addr_r, cmd_addr_s;
  logic              cmd_valid_r, cmd_valid_s;
  logic              wr_grant_r, wr_grant_s;
  logic              rd_grant_r, rd_grant_s;
  logic              wr_done_r, wr_done_s;
  logic              rd_done_r, rd_done_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic [7:0]        retry_cnt_r, retry_cnt_s;
  logic              pick_wr_s;

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    prio_wr_s   = prio_wr_r;
    is_wr_s     = is_wr_r;
    cmd_s       = cmd_r;
    cmd_addr_s  = cmd_addr_r;
    cmd_valid_s = 1'b0;
    wr_grant_s  = 1'b0;
    rd_grant_s  = 1'b0;
    wr_done_s   = 1'b0;
    rd_done_s   = 1'b0;
    tmo_cnt_s   = tmo_cnt_r;
    retry_cnt_s = retry_cnt_r;
    // Write wins when it is the only requester or when it holds priority.
    pick_wr_s   = wr_req && (!rd_req || prio_wr_r);

    case (state_r)
      ST_IDLE: begin
        if (init_done && (wr_req || rd_req)) begin
          if (pick_wr_s) begin
            wr_grant_s = 1'b1;
            is_wr_s    = 1'b1;
            cmd_s      = CMD_WR;
            cmd_addr_s = wr_addr;
            prio_wr_s  = 1'b0;
          end else begin
            rd_grant_s = 1'b1;
            is_wr_s    = 1'b0;
            cmd_s      = CMD_RD;
            cmd_addr_s = rd_addr;
            prio_wr_s  = 1'b1;
          end
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Only strobe while busy is low: that covers the FSM's pre-refresh
        // window, in which it raises busy early.
        if (init_done && !fsm_busy) begin
          cmd_valid_s = 1'b1;
          tmo_cnt_s   = TMO_LOAD;
          state_s     = ST_WAIT_ACK;
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_WAIT_ACK: begin
        if (fsm_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (tmo_cnt_r == {TMO_W{1'b0}}) begin
          // Strobe was not taken: re-issue the same cmd/cmd_addr.
          if (retry_cnt_r != 8'hFF) begin
            retry_cnt_s = retry_cnt_r + 8'd1;
          end else begin
            retry_cnt_s = retry_cnt_r;
          end
          state_s = ST_ISSUE;
        end else begin
          tmo_cnt_s = tmo_cnt_r - TMO_W'(1'b1);
          state_s   = ST_WAIT_ACK;
        end
      end

      ST_WAIT_DONE: begin
        if (!fsm_busy) begin
          if (is_wr_r) begin
            wr_done_s = 1'b1;
          end else begin
            rd_done_s = 1'b1;
          end
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prio_wr_r   <= 1'b1;
      is_wr_r     <= 1'b0;
      cmd_r       <= 4'b0000;
      cmd_addr_r  <= {ADDR_W{1'b0}};
      cmd_valid_r <= 1'b0;
      wr_grant_r  <= 1'b0;
      rd_grant_r  <= 1'b0;
      wr_done_r   <= 1'b0;
      rd_done_r   <= 1'b0;
      tmo_cnt_r   <= {TMO_W{1'b0}};
      retry_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      prio_wr_r   <= prio_wr_s;
      is_wr_r     <= is_wr_s;
      cmd_r       <= cmd_s;
      cmd_addr_r  <= cmd_addr_s;
      cmd_valid_r <= cmd_valid_s;
      wr_grant_r  <= wr_grant_s;
      rd_grant_r  <= rd_grant_s;
      wr_done_r   <= wr_done_s;
      rd_done_r   <= rd_done_s;
      tmo_cnt_r   <= tmo_cnt_s;
      retry_cnt_r <= retry_cnt_s;
    end
  end

  assign wr_grant  = wr_grant_r;
  assign rd_grant  = rd_grant_r;
  assign wr_done   = wr_done_r;
  assign rd_done   = rd_done_r;
  assign cmd       = cmd_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_addr  = cmd_addr_r;
  assign retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Self-checking bench for ddr_cmd_arbiter. A behavioural command-FSM model
// drives fsm_busy; a transaction-level reference (round-robin rule, expected
// code/address, retry count) judges grants, strobes and completions. A second
// instance with AUTO_PRE=0 runs on the same stimulus to check the plain codes.
module tb_ddr_cmd_arbiter;
  localparam int AW  = 23;
  localparam int TMO = 4;

  logic          clk, rst, init_done, wr_req, rd_req, fsm_busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_grant, wr_done, rd_grant, rd_done, cmd_valid;
  logic [3:0]    cmd;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    retry_cnt;
  logic          np_wr_grant, np_wr_done, np_rd_grant, np_rd_done, np_cmd_valid;
  logic [3:0]    np_cmd;
  logic [AW-1:0] np_cmd_addr;
  logic [7:0]    np_retry_cnt;

  ddr_cmd_arbiter #(.ADDR_W(AW), .AUTO_PRE(1'b1), .ACK_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_done(rd_done),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .fsm_busy(fsm_busy), .retry_cnt(retry_cnt)
  );

  ddr_cmd_arbiter #(.ADDR_W(AW), .AUTO_PRE(1'b0), .ACK_TIMEOUT(TMO)) u_dut_np (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(np_wr_grant), .wr_done(np_wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(np_rd_grant), .rd_done(np_rd_done),
    .cmd(np_cmd), .cmd_valid(np_cmd_valid), .cmd_addr(np_cmd_addr),
    .fsm_busy(fsm_busy), .retry_cnt(np_retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            busy_left = 0;      // remaining busy cycles of the FSM model
  int            cmd_dur = 3;        // busy length the model spends per command
  int            ignore_cnt = 0;     // strobes the model will drop
  int            exp_retry = 0;
  int            last_valid_cyc = 0;
  int            n_done = 0;
  bit            force_busy = 1'b0;  // refresh held by the bench
  bit            out_pending = 1'b0; // a granted command is not yet done
  bit            last_wr = 1'b0;     // last served client was the writer
  bit            exp_is_wr = 1'b0;
  bit            retry_due = 1'b0;
  bit            accepted = 1'b0;
  logic [AW-1:0] exp_addr = '0;

  function automatic int code(input bit is_wr, input bit autop);
    if (is_wr) return autop ? 4 : 2;
    else return autop ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic set_force(input bit b);
    force_busy = b;
    fsm_busy   = (busy_left > 0) || force_busy;
  endtask

  // One clock: FSM model reaction, then transaction-level checks of outputs.
  task automatic tick();
    logic          busy_b, init_b, wreq_b, rreq_b, valid_b, exp_wr;
    logic [AW-1:0] waddr_b, raddr_b;
    busy_b = fsm_busy; init_b = init_done; wreq_b = wr_req; rreq_b = rd_req;
    valid_b = cmd_valid; waddr_b = wr_addr; raddr_b = rd_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (busy_left > 0) busy_left--;
    if (valid_b) begin
      if (ignore_cnt > 0) begin
        ignore_cnt--;
        retry_due = 1'b1;
        exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
      end else begin
        busy_left += cmd_dur;
        accepted = 1'b1;
      end
    end
    fsm_busy = (busy_left > 0) || force_busy;

    if (wr_grant || rd_grant) begin
      exp_wr = (wreq_b && rreq_b) ? !last_wr : wreq_b;
      check("one_grant", 32'(wr_grant & rd_grant), 0);
      check("grant_when_free", 32'(out_pending), 0);
      check("grant_has_req", 32'(wreq_b | rreq_b), 1);
      check("grant_init", 32'(init_b), 1);
      check("rr_winner_wr", 32'(wr_grant), 32'(exp_wr));
      check("np_grant_wr", 32'(np_wr_grant), 32'(exp_wr));
      last_wr   = exp_wr;
      exp_is_wr = exp_wr;
      exp_addr  = exp_wr ? waddr_b : raddr_b;
      check("grant_cmd", 32'(cmd), code(exp_wr, 1'b1));
      check("grant_addr", 32'(cmd_addr), 32'(exp_addr));
      out_pending = 1'b1;
      accepted    = 1'b0;
      if (wr_grant) wr_req = 1'b0;
      if (rd_grant) rd_req = 1'b0;
    end

    if (cmd_valid) begin
      check("valid_not_back_to_back", 32'(valid_b), 0);
      check("valid_busy_low", 32'(busy_b), 0);
      check("valid_init", 32'(init_b), 1);
      check("valid_pending", 32'(out_pending), 1);
      check("valid_cmd", 32'(cmd), code(exp_is_wr, 1'b1));
      check("valid_addr", 32'(cmd_addr), 32'(exp_addr));
      check("np_valid", 32'(np_cmd_valid), 1);
      check("np_cmd", 32'(np_cmd), code(exp_is_wr, 1'b0));
      check("np_addr", 32'(np_cmd_addr), 32'(exp_addr));
      // Re-issue: ACK_TIMEOUT cycles in WAIT_ACK plus one ISSUE cycle.
      if (retry_due) check("retry_gap", cyc - last_valid_cyc, TMO + 1);
      retry_due = 1'b0;
      last_valid_cyc = cyc;
    end

    if (wr_done || rd_done) begin
      check("one_done", 32'(wr_done & rd_done), 0);
      check("done_pending", 32'(out_pending), 1);
      check("done_type_wr", 32'(wr_done), 32'(exp_is_wr));
      check("done_after_busy", 32'(accepted && (busy_left == 0)), 1);
      check("done_busy_low", 32'(busy_b), 0);
      check("done_no_valid", 32'(cmd_valid), 0);
      check("np_done_wr", 32'(np_wr_done), 32'(exp_is_wr));
      check("np_done_rd", 32'(np_rd_done), 32'(!exp_is_wr));
      check("np_done_no_valid", 32'(np_cmd_valid), 0);
      check("retry_cnt", 32'(retry_cnt), exp_retry);
      check("np_retry_cnt", 32'(np_retry_cnt), exp_retry);
      out_pending = 1'b0;
      n_done++;
    end
  endtask

  // what: 0 grant, 1 strobe, 2 done. Bounded by budget cycles.
  task automatic wait_for(input int what, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      case (what)
        0:       hit = wr_grant | rd_grant;
        1:       hit = cmd_valid;
        default: hit = wr_done | rd_done;
      endcase
      if (hit) at = cyc;
    end
    check($sformatf("wait_timeout_%0d", what), 32'(hit), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wr_grant", 32'(wr_grant), 0);
    check("rst_rd_grant", 32'(rd_grant), 0);
    check("rst_wr_done", 32'(wr_done), 0);
    check("rst_rd_done", 32'(rd_done), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_addr", 32'(cmd_addr), 0);
    check("rst_retry_cnt", 32'(retry_cnt), 0);
    wr_req = 1'b0; rd_req = 1'b0;
    busy_left = 0; ignore_cnt = 0; exp_retry = 0;
    out_pending = 1'b0; last_wr = 1'b0; retry_due = 1'b0; accepted = 1'b0;
    set_force(1'b0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int t_g, t_v, t_v2, t_d;
    rst = 1'b1; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; fsm_busy = 1'b0;

    // Reset state, then a single write.
    do_reset();
    init_done = 1'b1;
    cmd_dur = 3;
    wr_addr = 23'h12345;
    wr_req = 1'b1;
    tick();
    check("t1_grant", 32'(wr_grant), 1);
    tick();
    check("t1_valid", 32'(cmd_valid), 1);
    check("t1_cmd", 32'(cmd), 32'h4);
    check("t1_addr", 32'(cmd_addr), 32'h12345);
    t_v = cyc;
    wait_for(2, 20, t_d);
    check("t1_wr_done", 32'(wr_done), 1);
    check("t1_done_latency", t_d - t_v, cmd_dur + 2);

    // Both clients requesting: write, read, write after reset.
    do_reset();
    init_done = 1'b1;
    wr_addr = 23'($urandom); rd_addr = 23'($urandom);
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 10, t_g);
      check("t2_order_wr", 32'(wr_grant), (k == 1) ? 0 : 1);
      wait_for(2, 30, t_d);
      if (k < 2 && !wr_req) begin wr_addr = 23'($urandom); wr_req = 1'b1; end
      if (k < 2 && !rd_req) begin rd_addr = 23'($urandom); rd_req = 1'b1; end
    end
    // Remaining read request, checked on the plain-code instance too.
    wait_for(0, 10, t_g);
    check("t5_rd_grant", 32'(rd_grant), 1);
    wait_for(1, 10, t_v);
    check("t5_np_cmd", 32'(np_cmd), 32'h1);
    wait_for(2, 30, t_d);
    check("t5_np_rd_done", 32'(np_rd_done), 1);

    // Refresh holds busy high for 12 cycles while a request is pending.
    set_force(1'b1);
    rd_addr = 23'h0ABCDE; rd_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t3_no_valid_busy", 32'(cmd_valid), 0);
    end
    set_force(1'b0);
    tick();
    check("t3_valid_first_low", 32'(cmd_valid), 1);
    wait_for(2, 30, t_d);

    // First strobe dropped by the FSM: identical re-issue, retry_cnt=1.
    ignore_cnt = 1;
    wr_addr = 23'h7F00F1; wr_req = 1'b1;
    wait_for(1, 10, t_v);
    wait_for(1, 20, t_v2);
    check("t4_gap", t_v2 - t_v, TMO + 1);
    check("t4_cmd", 32'(cmd), 32'h4);
    check("t4_addr", 32'(cmd_addr), 32'h7F00F1);
    wait_for(2, 30, t_d);
    check("t4_retry_cnt", 32'(retry_cnt), 1);

    // init_done falling in ISSUE holds the strobe until it returns.
    set_force(1'b1);
    wr_addr = 23'h000321; wr_req = 1'b1;
    wait_for(0, 10, t_g);
    init_done = 1'b0;
    set_force(1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("init_hold", 32'(cmd_valid), 0);
    end
    init_done = 1'b1;
    tick();
    check("init_resume", 32'(cmd_valid), 1);
    wait_for(2, 30, t_d);

    // Reset during WAIT_DONE: no done pulse, next request served normally.
    cmd_dur = 8;
    rd_addr = 23'h1234AB; rd_req = 1'b1;
    wait_for(1, 10, t_v);
    tick(); tick(); tick();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_no_done", 32'(wr_done | rd_done), 0);
    end
    cmd_dur = 2;
    wr_addr = 23'h055555; wr_req = 1'b1;
    wait_for(0, 10, t_g);
    check("t6_wr_grant", 32'(wr_grant), 1);
    wait_for(2, 30, t_d);
    check("t6_wr_done", 32'(wr_done), 1);

    // Randomized traffic with refreshes and dropped strobes.
    for (int n = 0; n < 1500; n++) begin
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_addr = 23'($urandom); wr_req = 1'b1;
      end
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_addr = 23'($urandom); rd_req = 1'b1;
      end
      cmd_dur = $urandom_range(1, 6);
      if (!out_pending && ignore_cnt == 0 && $urandom_range(0, 9) == 0) ignore_cnt = 1;
      if (!out_pending && busy_left == 0 && !fsm_busy && $urandom_range(0, 19) == 0) begin
        busy_left = $urandom_range(3, 10);
        fsm_busy = 1'b1;
      end
      tick();
    end
    ignore_cnt = 0;
    for (int n = 0; n < 300 && (out_pending || wr_req || rd_req || busy_left > 0); n++) tick();
    check("drain_idle", 32'(out_pending | wr_req | rd_req), 0);
    check("traffic_seen", (n_done > 40) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
